pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined add/subtract built from 8-bit carry-look-ahead stages
//
// One pipeline stage per 8-bit block (NSTAGES = WIDTH/8). Stage k adds
// operand byte k using the carry registered by stage k-1. The upper operand
// bytes it has not consumed yet, and the lower sum bytes already computed,
// travel alongside the data. The last stage register is the output register.
//
// Optional feature: define PIPELINED_CLA_ADDER_FLAGS_EN to compute and
// register flag_z / flag_n / flag_v. Without it the flags are tied to 0.
//
// Ports:
//   clk        clock, all state on rising edge
//   reset      synchronous active-high reset
//   in_valid   operands presented
//   in_ready   operands accepted this cycle (equals the pipeline advance enable)
//   A, B       operands, WIDTH bits
//   cin        carry-in (add mode only)
//   sub        1: A - B, 0: A + B + cin
//   out_valid  output registers hold a result
//   out_ready  consumer takes the result this cycle
//   S          sum / difference
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   flag_z, flag_n, flag_v  zero / negative / signed overflow

module pipelined_cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  localparam int NSTAGES = WIDTH / 8;

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Whole pipeline moves together; it only stops when a finished result
  // is sitting in the output register and the consumer refuses it.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Subtraction is A + ~B + 1; cin is irrelevant then.
  assign b_eff = sub ? ~B : B;
  assign c_eff = sub | cin;

  // 8-bit look-ahead block: returns {carry_out, sum[7:0]}.
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b,
                                      input logic ci);
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

  for (genvar k = 0; k < NSTAGES; k++) begin : stg
    localparam int UW = WIDTH - 8 * (k + 1);  // operand bits still to consume

    logic [7:0]         a_blk;
    logic [7:0]         b_blk;
    logic               c_blk;
    logic               v_in;
    logic [8:0]         res;
    logic [8*k+7:0]     sum_nx;
    logic [8*k+7:0]     sum_q;
    logic               c_q;
    logic               v_q;

    if (k == 0) begin : g_src
      assign a_blk  = A[7:0];
      assign b_blk  = b_eff[7:0];
      assign c_blk  = c_eff;
      assign v_in   = in_valid;
      assign sum_nx = res[7:0];
    end else begin : g_src
      assign a_blk  = stg[k-1].g_fwd.a_q[7:0];
      assign b_blk  = stg[k-1].g_fwd.b_q[7:0];
      assign c_blk  = stg[k-1].c_q;
      assign v_in   = stg[k-1].v_q;
      assign sum_nx = {res[7:0], stg[k-1].sum_q};
    end

    assign res = cla8(a_blk, b_blk, c_blk);

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= res[8];
        sum_q <= sum_nx;
      end
    end

    // Operand bytes not yet consumed ride along to the later stages.
    if (k < NSTAGES - 1) begin : g_fwd
      logic [UW-1:0] a_nx;
      logic [UW-1:0] b_nx;
      logic [UW-1:0] a_q;
      logic [UW-1:0] b_q;

      if (k == 0) begin : g_sel
        assign a_nx = A[WIDTH-1:8];
        assign b_nx = b_eff[WIDTH-1:8];
      end else begin : g_sel
        assign a_nx = stg[k-1].g_fwd.a_q[UW+7:8];
        assign b_nx = stg[k-1].g_fwd.b_q[UW+7:8];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_nx;
          b_q <= b_nx;
        end
      end
    end

`ifdef PIPELINED_CLA_ADDER_FLAGS_EN
    if (k == NSTAGES - 1) begin : g_flg
      logic z_q;
      logic n_q;
      logic v_ovf_q;
      logic c_into_msb;

      // Carry into bit 7 of this block recovered from its sum and propagate bits.
      assign c_into_msb = a_blk[7] ^ b_blk[7] ^ res[7];

      always_ff @(posedge clk) begin
        if (reset) begin
          z_q     <= 1'b0;
          n_q     <= 1'b0;
          v_ovf_q <= 1'b0;
        end else if (adv) begin
          z_q     <= (sum_nx == '0);
          n_q     <= sum_nx[WIDTH-1];
          v_ovf_q <= res[8] ^ c_into_msb;
        end
      end
    end
`endif
  end

  assign S         = stg[NSTAGES-1].sum_q;
  assign cout      = stg[NSTAGES-1].c_q;
  assign out_valid = stg[NSTAGES-1].v_q;

`ifdef PIPELINED_CLA_ADDER_FLAGS_EN
  assign flag_z = stg[NSTAGES-1].g_flg.z_q;
  assign flag_n = stg[NSTAGES-1].g_flg.n_q;
  assign flag_v = stg[NSTAGES-1].g_flg.v_ovf_q;
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - scoreboard bench for pipelined_cla_adder (WIDTH=32 and WIDTH=8)

module tb_pipelined_cla_adder;

  localparam int W      = 32;
  localparam int NST    = W / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  s;
  logic          cout;
  logic          flag_z;
  logic          flag_n;
  logic          flag_v;

  logic          iv8;
  logic          ir8;
  logic [7:0]    a8;
  logic [7:0]    b8;
  logic          ov8;
  logic [7:0]    s8;
  logic          co8;
  logic          z8;
  logic          n8;
  logic          v8;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic [2:0]   znv;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .S(s), .cout(cout),
    .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v)
  );

  pipelined_cla_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8),
    .A(a8), .B(b8), .cin(1'b0), .sub(1'b0), .out_valid(ov8),
    .out_ready(1'b1), .S(s8), .cout(co8),
    .flag_z(z8), .flag_n(n8), .flag_v(v8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags only exist when the feature is built in; otherwise they must read 0.
  function automatic logic [2:0] fl(input logic [2:0] x);
`ifdef PIPELINED_CLA_ADDER_FLAGS_EN
    return x;
`else
    return 3'b000 & x;
`endif
  endfunction

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic sb);
    exp_t         e;
    logic [W-1:0] ye;
    logic [W:0]   r;
    ye    = sb ? ~y : y;
    r     = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
    e.s   = r[W-1:0];
    e.c   = r[W];
    e.znv = fl({(r[W-1:0] == '0), r[W-1], (x[W-1] == ye[W-1]) && (r[W-1] != x[W-1])});
    return e;
  endfunction

  // Handshakes happen on the next rising edge; inputs are stable at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("sb_S", s, e.s);
          check("sb_cout", cout, e.c);
          check("sb_flags", {flag_z, flag_n, flag_v}, e.znv);
        end
      end
      if (in_valid && in_ready) sb_q.push_back(model(a, b, cin, sub));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic ci, input logic sb, input logic [W-1:0] es,
                         input logic ec, input logic [2:0] eznv);
    int n;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, NST - 1);
    check({tag, "_S"}, s, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_flags"}, {flag_z, flag_n, flag_v}, fl(eznv));
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 200) begin
      tick();
      n++;
    end
    check("drain_timeout", (n >= 200), 0);
  endtask

  initial begin
    logic [W-1:0] pick [5];
    int n;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_S", s, 0);
    check("rst_cout", cout, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_flags", {flag_z, flag_n, flag_v}, 0);

    run_one("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 3'b100);
    run_one("sub", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 3'b010);
    run_one("ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 3'b011);
    run_one("cin", 32'h0000_00FF, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0200, 1'b0, 3'b000);
    drain();

    // Back-to-back with a stalled consumer.
    out_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; a = W'(i); b = W'(i); cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      check("stall_S", s, 2);
      check("stall_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    check("b2b_S0", s, 2);
    tick();
    check("b2b_S1", s, 4);
    check("b2b_v1", out_valid, 1);
    tick();
    check("b2b_S2", s, 6);
    check("b2b_v2", out_valid, 1);
    tick();
    check("b2b_empty", out_valid, 0);
    drain();

    // Random traffic with random back-pressure.
    pick[0] = '0; pick[1] = '1; pick[2] = 32'h7FFF_FFFF; pick[3] = 32'h8000_0000;
    for (int i = 0; i < 300; i++) begin
      pick[4]   = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : W'($urandom);
      b         = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : W'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = W'(10 + i); b = W'(3); cin = 1'b0; sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_S", s, 0);
    check("flush_in_ready", in_ready, 1);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      tick();
    end
    check("flush_no_stale", n, 0);

    // 8-bit build: single stage, one-cycle latency.
    iv8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
    check("w8_pre_valid", ov8, 0);
    check("w8_in_ready", ir8, 1);
    tick();
    iv8 = 1'b0;
    check("w8_valid", ov8, 1);
    check("w8_S", s8, 8'h00);
    check("w8_cout", co8, 1);
    check("w8_flags", {z8, n8, v8}, fl(3'b101));
    tick();
    check("w8_empty", ov8, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
